// File: rtl/msi_snoop_bus.sv
// Shared MSI snooping bus: round-robin arbitration over NUM_CORES requesters,
// snoop broadcast, remote-M flush forwarding and a latency-modelled backing memory.
module msi_snoop_bus #(
    parameter int NUM_CORES   = 2,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [2*NUM_CORES-1:0]        req_op,
    input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
    input  logic [DATA_W*NUM_CORES-1:0]   req_wdata,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic [NUM_CORES-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          snoop_valid,
    output logic [1:0]                    snoop_op,
    output logic [ADDR_W-1:0]             snoop_addr,
    output logic [2:0]                    snoop_src,
    input  logic [NUM_CORES-1:0]          snoop_hit_m,
    input  logic [DATA_W*NUM_CORES-1:0]   snoop_data,
    output logic                          bus_err,
    output logic [15:0]                   txn_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SNOOP     = 3'd1;
    localparam logic [2:0] S_SNOOP_RSP = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    localparam logic [1:0] OP_WB   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_RDX  = 2'd2;
    localparam logic [1:0] OP_UPGR = 2'd3;

    localparam logic [3:0] LAT_LAST = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

    logic [2:0]          state;
    logic [2:0]          rr_ptr;
    logic [2:0]          grant_q;
    logic [3:0]          lat_cnt;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [NUM_CORES-1:0] rot;
    logic                 arb_found;
    logic [3:0]           arb_off;
    logic [3:0]           arb_sum;
    logic [2:0]           arb_idx;
    logic [1:0]           sel_op;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    // Rotating the request vector by rr_ptr turns round-robin into a plain first-one search.
    assign rot = NUM_CORES'({req_valid, req_valid} >> rr_ptr);

    always_comb begin
        arb_found = 1'b0;
        arb_off   = 4'd0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!arb_found && rot[i]) begin
                arb_found = 1'b1;
                arb_off   = 4'(i);
            end
        end
        arb_sum = {1'b0, rr_ptr} + arb_off;
        arb_idx = (arb_sum >= 4'(NUM_CORES)) ? 3'(arb_sum - 4'(NUM_CORES)) : 3'(arb_sum);
    end

    always_comb begin
        sel_op    = 2'd0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (arb_idx == 3'(i)) begin
                sel_op    = req_op[2*i +: 2];
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    logic [NUM_CORES-1:0] grant_oh;
    logic [NUM_CORES-1:0] remote_hit;
    logic                 any_hit;
    logic                 multi_hit;
    logic [DATA_W-1:0]    hit_data;
    logic                 rd_op;
    logic                 flush;
    logic                 mem_acc;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_wd;

    assign grant_oh   = NUM_CORES'(1) << grant_q;
    assign remote_hit = snoop_hit_m & ~grant_oh;
    assign any_hit    = |remote_hit;
    assign multi_hit  = |(remote_hit & (remote_hit - NUM_CORES'(1)));
    assign rd_op      = (op_q == OP_RD) || (op_q == OP_RDX);
    assign flush      = (state == S_SNOOP_RSP) && rd_op && any_hit;

    // Descending scan so the lowest-index holder's data is the one that sticks.
    always_comb begin
        hit_data = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (remote_hit[i]) hit_data = snoop_data[DATA_W*i +: DATA_W];
        end
    end

    always_comb begin
        mem_acc = ((state == S_MEM) && (lat_cnt == 4'd0)) ||
                  ((state == S_SNOOP_RSP) && (MEM_LATENCY == 0) && !flush && (op_q != OP_UPGR));
        mem_we  = 1'b0;
        mem_wd  = wdata_q;
        if (flush) begin
            mem_we = 1'b1;
            mem_wd = hit_data;
        end else if (mem_acc && (op_q == OP_WB)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && arb_found) begin
            op_q    <= sel_op;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            rr_ptr      <= 3'd0;
            grant_q     <= 3'd0;
            lat_cnt     <= 4'd0;
            bus_err     <= 1'b0;
            txn_count   <= 16'd0;
            resp_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        grant_q <= arb_idx;
                        state   <= S_SNOOP;
                    end
                end
                S_SNOOP: state <= S_SNOOP_RSP;
                S_SNOOP_RSP: begin
                    if (multi_hit || (any_hit && !rd_op)) bus_err <= 1'b1;
                    if (op_q == OP_UPGR) begin
                        resp_data_q <= '0;
                        state       <= S_RESP;
                    end else if (flush) begin
                        resp_data_q <= hit_data;
                        state       <= S_RESP;
                    end else if (mem_acc) begin
                        resp_data_q <= (op_q == OP_WB) ? '0 : mem[addr_q];
                        state       <= S_RESP;
                    end else begin
                        lat_cnt <= LAT_LAST;
                        state   <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (lat_cnt == 4'd0) begin
                        resp_data_q <= (op_q == OP_WB) ? '0 : mem[addr_q];
                        state       <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    txn_count <= txn_count + 16'd1;
                    rr_ptr    <= (grant_q == 3'(NUM_CORES - 1)) ? 3'd0 : grant_q + 3'd1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by state so nothing stale leaks onto the bus between transactions.
    assign req_ready   = (resetn && state == S_IDLE && arb_found) ? (NUM_CORES'(1) << arb_idx) : '0;
    assign snoop_valid = (state == S_SNOOP);
    assign snoop_op    = snoop_valid ? op_q : 2'd0;
    assign snoop_addr  = snoop_valid ? addr_q : '0;
    assign snoop_src   = snoop_valid ? grant_q : 3'd0;
    assign resp_valid  = (state == S_RESP) ? grant_oh : '0;
    assign resp_data   = (state == S_RESP) ? resp_data_q : '0;

endmodule
